// File: rtl/mont_multicore_ctrl.sv
// Command-driven sequencer for NCORE Montgomery multiplier lanes: operand load, multiply, readback.
// Optional multiply watchdog enabled by defining MONT_WRAP_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a command word on port1
// LOAD      | waiting for bram_din_valid to capture the selected operand
// MUL_START | one-cycle core_start pulse, done mask cleared
// MUL_WAIT  | collecting per-lane done bits (and watchdog when enabled)
// WRITE     | presenting the result register on bram_dout until read
// DONE      | signalling completion on port2 until acknowledged
module mont_multicore_ctrl #(
    parameter int NCORE       = 2,
    parameter int DATA_W      = 512,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [31:0]             port1_din,
    input  logic                    port1_valid,
    output logic                    port1_read,
    output logic                    port2_valid,
    input  logic                    port2_read,
    input  logic [NCORE*DATA_W-1:0] bram_din,
    input  logic                    bram_din_valid,
    output logic [NCORE*DATA_W-1:0] bram_dout,
    output logic                    bram_dout_valid,
    input  logic                    bram_dout_read,
    output logic [NCORE*DATA_W-1:0] core_a,
    output logic [NCORE*DATA_W-1:0] core_b,
    output logic [NCORE*DATA_W-1:0] core_m,
    output logic                    core_start,
    input  logic [NCORE*DATA_W-1:0] core_result,
    input  logic [NCORE-1:0]        core_done,
    output logic                    err,
    output logic [3:0]              leds
);

    localparam int W = NCORE * DATA_W;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD      = 4'd1,
        MUL_START = 4'd2,
        MUL_WAIT  = 4'd3,
        WRITE     = 4'd4,
        DONE      = 4'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       opcode;
    logic [1:0]       op_sel;
    logic [NCORE-1:0] done_mask;
    logic [NCORE-1:0] done_all;
    logic             all_done;
    logic [W-1:0]     rslt;
    logic             tmo;
    logic             unused_din;

    assign opcode     = port1_din[3:0];
    assign unused_din = ^port1_din[31:4];
    // done bits arriving in the exit cycle count toward completion
    assign done_all   = done_mask | core_done;
    assign all_done   = &done_all;
    assign bram_dout  = rslt;
    assign leds       = state;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (port1_valid) begin
                    case (opcode)
                        4'd0, 4'd1, 4'd2: state_nxt = LOAD;
                        4'd3:             state_nxt = MUL_START;
                        4'd4:             state_nxt = WRITE;
                        default:          state_nxt = DONE;
                    endcase
                end
            end
            LOAD:      if (bram_din_valid) state_nxt = DONE;
            MUL_START: state_nxt = MUL_WAIT;
            MUL_WAIT:  if (all_done || tmo) state_nxt = DONE;
            WRITE:     if (bram_dout_valid && bram_dout_read) state_nxt = DONE;
            DONE:      if (port2_valid && port2_read) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            port1_read      <= 1'b0;
            port2_valid     <= 1'b0;
            bram_dout_valid <= 1'b0;
            core_start      <= 1'b0;
            op_sel          <= 2'd0;
            core_a          <= '0;
            core_b          <= '0;
            core_m          <= '0;
            rslt            <= '0;
            done_mask       <= '0;
        end else begin
            port1_read      <= (state == IDLE) && port1_valid;
            core_start      <= (state_nxt == MUL_START);
            // valid strobes rise one cycle after entering their state and drop on handshake
            bram_dout_valid <= (state == WRITE) && !(bram_dout_valid && bram_dout_read);
            port2_valid     <= (state == DONE) && !(port2_valid && port2_read);
            case (state)
                IDLE: if (port1_valid) op_sel <= opcode[1:0];
                LOAD: begin
                    if (bram_din_valid) begin
                        case (op_sel)
                            2'd0:    core_a <= bram_din;
                            2'd1:    core_b <= bram_din;
                            default: core_m <= bram_din;
                        endcase
                    end
                end
                MUL_START: done_mask <= '0;
                MUL_WAIT: begin
                    done_mask <= done_all;
                    if (all_done) rslt <= core_result;
                    else if (tmo) rslt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef MONT_WRAP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CNT_W-1:0] tmo_cnt;

    // down-counter loaded in MUL_START; terminal count ends the TIMEOUT_CYC-th wait cycle
    assign tmo = (tmo_cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == MUL_START)
                tmo_cnt <= CNT_W'(TIMEOUT_CYC - 1);
            else if (state == MUL_WAIT && !tmo)
                tmo_cnt <= tmo_cnt - CNT_W'(1);

            if (state == MUL_WAIT && tmo && !all_done)
                err <= 1'b1;
            else if (state == IDLE && port1_valid && opcode == 4'd5)
                err <= 1'b0;
        end
    end
`else
    logic unused_tmo;

    assign tmo        = 1'b0;
    assign err        = 1'b0;
    assign unused_tmo = (TIMEOUT_CYC != 0);
`endif

endmodule
